// File: rtl/rll_key_loader.sv
// Serial key loader for an RLL-locked core: shifts an even-parity key frame
// in LSB first and commits it atomically onto key_out (bit i -> keyIn_0_i).
module rll_key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int LOCK_ONCE = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 key_sdata,
  input  logic                 key_sen,
  input  logic                 key_clear,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_err
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    CHECK
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 par_q, par_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q;
  logic                 can_start;

  assign can_start = (LOCK_ONCE == 0) || !valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      par_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      par_q    <= par_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    par_d    = par_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (key_clear) begin
      state_d  = IDLE;
      shadow_d = '0;
      key_d    = '0;
      cnt_d    = '0;
      tmo_d    = '0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_start && can_start) begin
            state_d  = SHIFT;
            shadow_d = '0;
            cnt_d    = '0;
            tmo_d    = '0;
            err_d    = 1'b0;
          end
        end
        SHIFT, PARITY: begin
          if (load_start) begin
            // restart the frame; a same-cycle strobe is dropped
            state_d  = SHIFT;
            shadow_d = '0;
            cnt_d    = '0;
            tmo_d    = '0;
          end else if (key_sen) begin
            tmo_d = '0;
            if (state_q == SHIFT) begin
              // shadow was zeroed at frame start, so OR-in is enough
              shadow_d = shadow_q
                | (KEY_WIDTH'(key_sdata) << cnt_q);
              cnt_d = cnt_q + CW'(1);
              if (cnt_q == LAST) begin
                state_d = PARITY;
              end
            end else begin
              par_d   = key_sdata;
              state_d = CHECK;
            end
          end else if (tmo_q == TLAST) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        CHECK: begin
          if ((^shadow_q ^ par_q) == 1'b0) begin
            key_d   = shadow_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: commit, parity error, lock-once,
// timeout, abort/restart, async reset and clear-over-commit.
module tb_rll_key_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        key_sdata;
  logic        key_sen;
  logic        key_clear;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        load_err;

  int n_cmp;
  int n_bad;

  rll_key_loader #(
    .KEY_WIDTH(32),
    .LOCK_ONCE(1),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .key_sdata (key_sdata),
    .key_sen   (key_sen),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_start = 1'b0;
    key_sdata  = 1'b0;
    key_sen    = 1'b0;
    key_clear  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v,
                           input int n,
                           input int gap);
    for (int i = 0; i < n; i++) begin
      key_sen   = 1'b1;
      key_sdata = v[i];
      tick();
      key_sen   = 1'b0;
      key_sdata = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // ends #1 after the edge that samples the parity bit
  task automatic send_frame(input logic [31:0] v,
                            input logic p,
                            input int gap);
    pulse_start();
    send_bits(v, 32, gap);
    key_sen   = 1'b1;
    key_sdata = p;
    tick();
    key_sen   = 1'b0;
    key_sdata = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // reset state
    rst_n      = 1'b0;
    load_start = 1'b0;
    key_sdata  = 1'b0;
    key_sen    = 1'b0;
    key_clear  = 1'b0;
    #2;
    chk("rst_key", key_out, 32'h0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    do_reset();

    // 1: good frame, back-to-back strobes
    send_frame(32'hA5A5_0F0F, 1'b0, 0);
    chk("t1_lat_valid", 32'(key_valid), 32'd0);
    chk("t1_lat_key", key_out, 32'h0);
    chk("t1_check_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_key", key_out, 32'hA5A5_0F0F);
    chk("t1_valid", 32'(key_valid), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: bad parity
    do_reset();
    send_frame(32'hA5A5_0F0F, 1'b1, 0);
    tick();
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_valid", 32'(key_valid), 32'd0);
    chk("t2_key", key_out, 32'h0);
    repeat (3) tick();
    chk("t2_err_sticky", 32'(load_err), 32'd1);

    // 3: lock-once, then clear and reload
    do_reset();
    send_frame(32'h0000_0001, 1'b1, 0);
    tick();
    chk("t3_key1", key_out, 32'h0000_0001);
    pulse_start();
    chk("t3_locked_busy", 32'(busy), 32'd0);
    send_bits(32'hFFFF_FFFF, 32, 0);
    key_sen = 1'b1;
    tick();
    key_sen = 1'b0;
    tick();
    chk("t3_locked_key", key_out, 32'h0000_0001);
    chk("t3_locked_valid", 32'(key_valid), 32'd1);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk("t3_clr_key", key_out, 32'h0);
    chk("t3_clr_valid", 32'(key_valid), 32'd0);
    send_frame(32'hFFFF_FFFF, 1'b0, 0);
    tick();
    chk("t3_key2", key_out, 32'hFFFF_FFFF);
    chk("t3_valid2", 32'(key_valid), 32'd1);

    // 4: timeout after 10 bits
    do_reset();
    pulse_start();
    send_bits(32'h0000_03FF, 10, 0);
    repeat (3) tick();
    chk("t4_pre_err", 32'(load_err), 32'd0);
    chk("t4_pre_busy", 32'(busy), 32'd1);
    tick();
    chk("t4_err", 32'(load_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_key", key_out, 32'h0);
    chk("t4_valid", 32'(key_valid), 32'd0);
    pulse_start();
    chk("t4_restart_err", 32'(load_err), 32'd0);
    chk("t4_restart_busy", 32'(busy), 32'd1);

    // 5: abort after 20 bits, then gapped frame
    do_reset();
    pulse_start();
    send_bits(32'hFFFF_FFFF, 20, 0);
    send_frame(32'h1234_5678, 1'b1, 3);
    chk("t5_lat_valid", 32'(key_valid), 32'd0);
    tick();
    chk("t5_key", key_out, 32'h1234_5678);
    chk("t5_valid", 32'(key_valid), 32'd1);
    chk("t5_err", 32'(load_err), 32'd0);

    // 6a: async reset with a committed key, and mid-SHIFT
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_key", key_out, 32'h0);
    chk("t6_rst_valid", 32'(key_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_bits(32'h0000_00FF, 8, 0);
    chk("t6_shift_busy", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_err", 32'(load_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 6b: clear in the CHECK cycle beats the commit
    send_frame(32'hA5A5_0F0F, 1'b0, 0);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk("t6_clr_key", key_out, 32'h0);
    chk("t6_clr_valid", 32'(key_valid), 32'd0);
    chk("t6_clr_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_clr_key2", key_out, 32'h0);
    chk("t6_clr_err", 32'(load_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
